// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage operand forwarding controller:
// mux select encodings and the in-flight tracking entry.
package fwd_pkg;

  localparam int FWD_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_SEL_RF    = 2'd0;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'd1;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'd2;

  typedef struct packed {
    logic                      valid;
    logic                      regwrite;
    logic                      memread;
    logic [FWD_REG_ADDR_W-1:0] rd;
  } fwd_ent_t;

endpackage

// File: rtl/fwd_src_sel.sv
// Priority compare of one ID source register against the EX and MEM
// tracking entries; purely combinational, the younger EX writer wins.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int W = FWD_REG_ADDR_W
) (
  input  logic [W-1:0] i_src,
  input  logic         i_ex_vld,
  input  logic         i_ex_wr,
  input  logic [W-1:0] i_ex_rd,
  input  logic         i_mem_vld,
  input  logic         i_mem_wr,
  input  logic [W-1:0] i_mem_rd,
  output logic [1:0]   o_sel
);

  logic w_src_nz;

  assign w_src_nz = (i_src != '0);

  always_comb begin
    o_sel = FWD_SEL_RF;
    if (w_src_nz && i_ex_vld && i_ex_wr && (i_ex_rd == i_src)) begin
      o_sel = FWD_SEL_EXMEM;
    end else if (w_src_nz && i_mem_vld && i_mem_wr && (i_mem_rd == i_src)) begin
      o_sel = FWD_SEL_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_mux_ctrl.sv
// Forwarding/load-use controller for the EX operand muxes; selects are registered into EX.
// Build option FWD_MUX_CTRL_STATS_EN adds a saturating stall-cycle counter.
module fwd_mux_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = FWD_REG_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic                  stall_o,
  output logic [15:0]           stall_cnt_o
);

  fwd_ent_t   r_ex, r_mem, r_wb;
  fwd_ent_t   w_ex_nxt;
  logic [1:0] r_sel_a, r_sel_b;
  logic [1:0] w_sel_a, w_sel_b;
  logic       w_stall;
  logic       w_issue;

  fwd_src_sel #(.W(REG_ADDR_W)) u_sel_a (
    .i_src    (id_rs_i),
    .i_ex_vld (r_ex.valid),
    .i_ex_wr  (r_ex.regwrite),
    .i_ex_rd  (r_ex.rd),
    .i_mem_vld(r_mem.valid),
    .i_mem_wr (r_mem.regwrite),
    .i_mem_rd (r_mem.rd),
    .o_sel    (w_sel_a)
  );

  fwd_src_sel #(.W(REG_ADDR_W)) u_sel_b (
    .i_src    (id_rt_i),
    .i_ex_vld (r_ex.valid),
    .i_ex_wr  (r_ex.regwrite),
    .i_ex_rd  (r_ex.rd),
    .i_mem_vld(r_mem.valid),
    .i_mem_wr (r_mem.regwrite),
    .i_mem_rd (r_mem.rd),
    .o_sel    (w_sel_b)
  );

  // A load in EX cannot forward yet; hold the consumer one cycle until it reaches MEM.
  assign w_stall = id_valid_i & ~flush_i & r_ex.valid & r_ex.memread & (r_ex.rd != '0) &
                   ((r_ex.rd == id_rs_i) | (r_ex.rd == id_rt_i));
  assign w_issue = id_valid_i & ~w_stall & ~flush_i;

  always_comb begin
    w_ex_nxt = '0;
    if (w_issue) begin
      w_ex_nxt.valid    = 1'b1;
      w_ex_nxt.regwrite = id_regwrite_i;
      w_ex_nxt.memread  = id_memread_i;
      w_ex_nxt.rd       = id_rd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_sel_a <= FWD_SEL_RF;
      r_sel_b <= FWD_SEL_RF;
    end else begin
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_ex_nxt;
      r_sel_a <= w_issue ? w_sel_a : FWD_SEL_RF;
      r_sel_b <= w_issue ? w_sel_b : FWD_SEL_RF;
    end
  end

  // WB only ages out (register-file write-before-read covers it); it must mirror last MEM.
  a_wb_ages: assert property (@(posedge clk_i) disable iff (rst_i) r_wb == $past(r_mem));

  assign fwd_a_sel_o = r_sel_a;
  assign fwd_b_sel_o = r_sel_b;
  assign stall_o     = w_stall;

`ifdef FWD_MUX_CTRL_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_mux_ctrl.sv
// Directed bench for fwd_mux_ctrl: forwarding selects, load-use stall, flush and reset.
// Stall-count expectations follow FWD_MUX_CTRL_STATS_EN.
module tb_fwd_mux_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        id_regwrite_i, id_memread_i, flush_i;
  logic [1:0]  fwd_a_sel_o, fwd_b_sel_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_cnt = 16'd0;

`ifdef FWD_MUX_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  fwd_mux_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_rd_i      (id_rd_i),
    .id_regwrite_i(id_regwrite_i),
    .id_memread_i (id_memread_i),
    .flush_i      (flush_i),
    .fwd_a_sel_o  (fwd_a_sel_o),
    .fwd_b_sel_o  (fwd_b_sel_o),
    .stall_o      (stall_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++; if (fwd_a_sel_o !== 2'd0) begin failures++; $display("FAIL reset_a: got %0d want 0", fwd_a_sel_o); end
    checks++; if (fwd_b_sel_o !== 2'd0) begin failures++; $display("FAIL reset_b: got %0d want 0", fwd_b_sel_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o); end
    tick(); tick();
    rst_i = 1'b0;
    idle(2);
  endtask

  task automatic test_ex_forward();
    tick(); drive(1, 0, 0, 3, 1, 0, 0);              // add r3
    tick(); drive(1, 3, 4, 9, 1, 0, 0);              // sub r9 <- r3, r4
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL ex_fwd_stall: got %0b want 0", stall_o); end
    tick();
    checks++; if (fwd_a_sel_o !== 2'd1) begin failures++; $display("FAIL ex_fwd_a: got %0d want 1", fwd_a_sel_o); end
    checks++; if (fwd_b_sel_o !== 2'd0) begin failures++; $display("FAIL ex_fwd_b: got %0d want 0", fwd_b_sel_o); end
    drive(1, 4, 9, 10, 1, 0, 0);                      // reader of r9 on operand B
    tick();
    checks++; if (fwd_a_sel_o !== 2'd0) begin failures++; $display("FAIL ex_fwd2_a: got %0d want 0", fwd_a_sel_o); end
    checks++; if (fwd_b_sel_o !== 2'd1) begin failures++; $display("FAIL ex_fwd2_b: got %0d want 1", fwd_b_sel_o); end
    idle(3);
  endtask

  task automatic test_mem_forward();
    tick(); drive(1, 0, 0, 5, 1, 0, 0);              // add r5
    tick(); drive(0, 0, 0, 0, 0, 0, 0);              // nop
    tick(); drive(1, 2, 5, 10, 1, 0, 0);             // or r10 <- r2, r5
    tick();
    checks++; if (fwd_a_sel_o !== 2'd0) begin failures++; $display("FAIL mem_fwd_a: got %0d want 0", fwd_a_sel_o); end
    checks++; if (fwd_b_sel_o !== 2'd2) begin failures++; $display("FAIL mem_fwd_b: got %0d want 2", fwd_b_sel_o); end
    idle(3);
    tick(); drive(1, 0, 0, 0, 1, 1, 0);              // lw r0
    tick(); drive(1, 0, 0, 11, 1, 0, 0);             // reader of r0 both operands
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rd0_stall: got %0b want 0", stall_o); end
    tick();
    checks++; if (fwd_a_sel_o !== 2'd0) begin failures++; $display("FAIL rd0_a: got %0d want 0", fwd_a_sel_o); end
    checks++; if (fwd_b_sel_o !== 2'd0) begin failures++; $display("FAIL rd0_b: got %0d want 0", fwd_b_sel_o); end
    idle(3);
  endtask

  task automatic test_load_use();
    checks++; if (stall_cnt_o !== exp_cnt) begin failures++; $display("FAIL lu_cnt_before: got %0d want %0d", stall_cnt_o, exp_cnt); end
    tick(); drive(1, 0, 0, 7, 1, 1, 0);              // lw r7
    tick(); drive(1, 7, 1, 13, 1, 0, 0);             // add r13 <- r7, r1
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall: got %0b want 1", stall_o); end
    tick();
    if (STATS) exp_cnt++;
    checks++; if (fwd_a_sel_o !== 2'd0) begin failures++; $display("FAIL lu_bubble_a: got %0d want 0", fwd_a_sel_o); end
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lu_stall_len: got %0b want 0", stall_o); end
    tick();
    checks++; if (fwd_a_sel_o !== 2'd2) begin failures++; $display("FAIL lu_fwd_a: got %0d want 2", fwd_a_sel_o); end
    checks++; if (fwd_b_sel_o !== 2'd0) begin failures++; $display("FAIL lu_fwd_b: got %0d want 0", fwd_b_sel_o); end
    checks++; if (stall_cnt_o !== exp_cnt) begin failures++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt_o, exp_cnt); end
    idle(3);
  endtask

  task automatic test_priority();
    tick(); drive(1, 0, 0, 6, 1, 0, 0);              // add r6
    tick(); drive(1, 0, 0, 6, 1, 0, 0);              // add r6 again
    tick(); drive(1, 6, 6, 14, 1, 0, 0);             // reader of r6 on both operands
    tick();
    checks++; if (fwd_a_sel_o !== 2'd1) begin failures++; $display("FAIL prio_a: got %0d want 1", fwd_a_sel_o); end
    checks++; if (fwd_b_sel_o !== 2'd1) begin failures++; $display("FAIL prio_b: got %0d want 1", fwd_b_sel_o); end
    idle(3);
  endtask

  task automatic test_flush();
    tick(); drive(1, 0, 0, 8, 1, 1, 0);              // lw r8
    tick(); drive(1, 8, 0, 15, 1, 0, 1);             // reader of r8, flushed
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall: got %0b want 0", stall_o); end
    tick();
    checks++; if (fwd_a_sel_o !== 2'd0) begin failures++; $display("FAIL flush_a: got %0d want 0", fwd_a_sel_o); end
    drive(1, 8, 0, 15, 1, 0, 0);                      // same reader, not flushed
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_bubble: got %0b want 0", stall_o); end
    tick();
    checks++; if (fwd_a_sel_o !== 2'd2) begin failures++; $display("FAIL flush_after_a: got %0d want 2", fwd_a_sel_o); end
    checks++; if (stall_cnt_o !== exp_cnt) begin failures++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt_o, exp_cnt); end
    idle(3);
  endtask

  task automatic test_reset_midstream();
    tick(); drive(1, 0, 0, 20, 1, 0, 0);             // add r20
    tick(); drive(1, 20, 0, 9, 1, 1, 0);             // lw r9 <- r20
    tick(); drive(1, 9, 9, 16, 1, 0, 0);             // reader of r9
    #1;
    checks++; if (fwd_a_sel_o !== 2'd1) begin failures++; $display("FAIL mid_pre_a: got %0d want 1", fwd_a_sel_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL mid_pre_stall: got %0b want 1", stall_o); end
    #1;
    rst_i = 1'b1;
    exp_cnt = 16'd0;
    #1;
    checks++; if (fwd_a_sel_o !== 2'd0) begin failures++; $display("FAIL mid_rst_a: got %0d want 0", fwd_a_sel_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL mid_rst_stall: got %0b want 0", stall_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin failures++; $display("FAIL mid_rst_cnt: got %0d want 0", stall_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL mid_hold_stall%0d: got %0b want 0", i, stall_o); end
    end
    rst_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL post_rst_stall: got %0b want 0", stall_o); end
    tick();
    checks++; if (fwd_a_sel_o !== 2'd0) begin failures++; $display("FAIL post_rst_a: got %0d want 0", fwd_a_sel_o); end
    checks++; if (fwd_b_sel_o !== 2'd0) begin failures++; $display("FAIL post_rst_b: got %0d want 0", fwd_b_sel_o); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_priority();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_mux_ctrl.md
Name: fwd_mux_ctrl

Overview:
- Sequencing controller for the two EX-stage 4-to-1 operand muxes (ALU src A and src B) in the 5-stage pipelined CPU.
- Tracks the destination register of every in-flight instruction (EX, MEM, WB).
- Computes the registered 2-bit select for each operand mux.
- Detects load-use hazards and stalls the front end while inserting a bubble.

Parameters:
- REG_ADDR_W, 5, register-file address width; register 0 is hardwired zero and never forwarded.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs_i  in  REG_ADDR_W  source A register of the ID instruction.
- id_rt_i  in  REG_ADDR_W  source B register of the ID instruction.
- id_rd_i  in  REG_ADDR_W  destination register of the ID instruction.
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  kill the ID instruction (taken branch/jump).
- fwd_a_sel_o  out  2  EX mux select, operand A (registered).
- fwd_b_sel_o  out  2  EX mux select, operand B (registered).
- stall_o  out  1  hold PC and IF/ID, bubble ID/EX (combinational).
- stall_cnt_o  out  16  stall-cycle count (see Optional Feature).

Behaviour:
- Select encoding:
  - 0 = register-file value.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB write-back data.
  - 3 = reserved; never driven.
- Tracking entries EX, MEM and WB each hold {valid, regwrite, memread, rd}.
- Reset:
  - All entries invalid.
  - fwd_a_sel_o = fwd_b_sel_o = 0.
  - stall_o = 0.
  - stall_cnt_o = 0.
- Per-operand select, computed in the ID cycle and registered into the EX cycle:
  - Let src be id_rs_i (for A) or id_rt_i (for B).
  - If src != 0, EX entry is valid with regwrite, and EX.rd == src: select 1.
  - Otherwise, if src != 0, MEM entry is valid with regwrite, and MEM.rd == src: select 2.
  - Otherwise: select 0.
  - EX match has priority over MEM match.
- Load-use stall:
  - stall_o = id_valid_i & ~flush_i & EX.valid & EX.memread & EX.rd != 0 & (EX.rd == id_rs_i | EX.rd == id_rt_i).
  - A single stall lasts exactly 1 cycle; after it the load sits in MEM, so the consumer gets select 2.
- Advance every cycle:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields if id_valid_i & ~stall_o & ~flush_i; otherwise EX <= bubble (valid = 0).
- Stall cycle:
  - Registered selects load 0.
  - ID inputs are held externally and re-evaluated in the next cycle.
- flush_i:
  - Overrides stall: stall_o = 0, EX <= bubble, selects <= 0.
  - Older MEM and WB entries still advance.
- The WB entry exists only to age out. Register-file write-before-read covers the WB-to-ID distance; no select is generated for it.
- rs == rt, both matching: both selects carry the same value.
- rd == 0 writers never produce a match and never cause a stall.
- Reset asserted mid-stream: all entries invalidate immediately (asynchronous); the first post-reset instruction sees select 0.

Optional Feature:
- Macro: FWD_MUX_CTRL_STATS_EN.
- Defined:
  - stall_cnt_o increments on every cycle with stall_o = 1.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i.
- Undefined:
  - stall_cnt_o is tied to 0 and no counter flops are built.
  - Port list is identical in both builds.

Decomposition:
- Shared package fwd_pkg:
  - Select encodings FWD_SEL_RF = 2'd0, FWD_SEL_EXMEM = 2'd1, FWD_SEL_MEMWB = 2'd2.
  - Tracking-entry struct typedef {valid, regwrite, memread, rd}.
  - Default REG_ADDR_W.
- One sub-module, fwd_src_sel: combinational priority compare of one source register against the EX/MEM entries, returning a 2-bit select. Instantiated twice (operands A and B).

Test Plan:
- Reset: assert rst_i mid-cycle -> all outputs 0 immediately; hold 3 cycles, no stall.
- EX forward: add r3 (rd=3), then sub with rs=3, rt=4 -> next cycle fwd_a_sel_o=1, fwd_b_sel_o=0.
- MEM forward: add r5, nop, then or with rs=2, rt=5 -> fwd_b_sel_o=2; also with rd=0 writer and rs=0 -> selects stay 0.
- Load-use:
  - Stimulus: lw r7, then add with rs=7.
  - stall_o=1 for exactly 1 cycle, EX bubble inserted.
  - Following cycle: fwd_a_sel_o=2.
  - With STATS_EN, stall_cnt_o=1.
- Priority: writes to r6 in two consecutive instructions, then a reader of r6 -> select 1 (youngest writer).
- Flush vs stall: lw r8, then a reader of r8 with flush_i=1 same cycle -> stall_o=0, EX bubble, selects 0 next cycle.
